// File: rtl/cfg_bitstream_loader.sv
// Fabric configuration loader: takes host bitstream words over valid/ready and
// shifts them, LSB first, into MX per-column config chains, committing each column with cset.
module cfg_bitstream_loader #(
  parameter int MX       = 3,
  parameter int COL_BITS = 256,
  parameter int WORD_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [MX-1:0]     cen,
  output logic [MX-1:0]     cset,
  output logic [MX-1:0]     shift_in,
  output logic              busy,
  output logic              done
);

  localparam int BC_W  = $clog2(COL_BITS + 1);
  localparam int COL_W = (MX > 1) ? $clog2(MX) : 1;
  localparam int WB_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(COL_BITS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(MX - 1);
  localparam logic [WB_W-1:0]  WB_LAST  = WB_W'(WORD_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_SET   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [COL_W-1:0]  col;
  logic [BC_W-1:0]   bc;
  logic [WORD_W-1:0] word_buf;
  logic              buf_vld;
  logic [WB_W-1:0]   wb;

  logic [WORD_W-1:0] cur_word;
  logic [WB_W-1:0]   cur_wb;
  logic              cur_bit;
  logic              col_end;
  logic              last_usable;
  logic              accept;
  logic              fire;
  logic [MX-1:0]     col_sel;

  // When the buffer is empty the incoming word is used directly (bypass), so the
  // first bit of every word goes out in the same cycle the word is accepted.
  always_comb begin
    cur_word    = buf_vld ? word_buf : in_data;
    cur_wb      = buf_vld ? wb : '0;
    cur_bit     = cur_word[cur_wb];
    col_end     = (bc == BC_LAST);
    last_usable = (cur_wb == WB_LAST) || col_end;
    in_ready    = busy && (state == S_SHIFT) && (!buf_vld || last_usable);
    accept      = in_valid && in_ready;
    fire        = (state == S_SHIFT) && (buf_vld || accept);
    col_sel     = MX'(1) << col;
  end

  // NOTE: the word buffer is pure datapath qualified by buf_vld, so it carries no
  // reset; only control state and outputs need a defined value after reset.
  always_ff @(posedge clk) begin
    if (accept) word_buf <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      col      <= '0;
      bc       <= '0;
      buf_vld  <= 1'b0;
      wb       <= '0;
      cen      <= '0;
      cset     <= '0;
      shift_in <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle; a later non-blocking
      // assignment in the same block overrides the default.
      cen  <= '0;
      cset <= '0;
      done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (done) begin
            busy <= 1'b0;
          end else if (start && !busy) begin
            state   <= S_SHIFT;
            busy    <= 1'b1;
            col     <= '0;
            bc      <= '0;
            buf_vld <= 1'b0;
            wb      <= '0;
          end
        end

        S_SHIFT: begin
          // Stall cycles leave shift_in untouched so the chain input stays stable.
          if (fire) begin
            cen      <= col_sel;
            shift_in <= cur_bit ? col_sel : '0;
            if (col_end) begin
              bc    <= '0;
              state <= S_SET;
            end else begin
              bc <= bc + 1'b1;
            end
          end

          if (buf_vld && accept) begin
            buf_vld <= 1'b1;
            wb      <= '0;
          end else if (fire) begin
            if (last_usable) begin
              buf_vld <= 1'b0;
            end else begin
              buf_vld <= 1'b1;
              wb      <= cur_wb + 1'b1;
            end
          end
        end

        S_SET: begin
          cset <= col_sel;
          if (col == COL_LAST) begin
            state <= S_DONE;
          end else begin
            col   <= col + 1'b1;
            state <= S_SHIFT;
          end
        end

        S_DONE: begin
          done     <= 1'b1;
          state    <= S_IDLE;
          col      <= '0;
          buf_vld  <= 1'b0;
          shift_in <= '0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// Self-checking bench for cfg_bitstream_loader: a fabric chain model records every
// shifted bit and is compared with the column bits expected from the supplied words.
module tb_cfg_bitstream_loader;

  localparam int MX  = 3;
  localparam int CB  = 40;
  localparam int WW  = 32;
  localparam int WPC = (CB + WW - 1) / WW;
  localparam int NW  = MX * WPC;
  localparam int BCB = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          start_a    = 1'b0;
  logic          in_valid_a = 1'b0;
  logic [WW-1:0] in_data_a  = '0;
  logic          in_ready_a;
  logic [MX-1:0] cen_a, cset_a, shift_in_a;
  logic          busy_a, done_a;

  logic          start_b    = 1'b0;
  logic          in_valid_b = 1'b0;
  logic [WW-1:0] in_data_b  = '0;
  logic          in_ready_b;
  logic [0:0]    cen_b, cset_b, shift_in_b;
  logic          busy_b, done_b;

  cfg_bitstream_loader #(.MX(MX), .COL_BITS(CB), .WORD_W(WW)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .cen(cen_a), .cset(cset_a), .shift_in(shift_in_a),
    .busy(busy_a), .done(done_a)
  );

  cfg_bitstream_loader #(.MX(1), .COL_BITS(BCB), .WORD_W(WW)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .cen(cen_b), .cset(cset_b), .shift_in(shift_in_b),
    .busy(busy_b), .done(done_b)
  );

  int tests = 0;
  int fails = 0;

  int cyc, first_cen, done_cnt, done_cyc, hs_cnt, viol;
  int gap_cnt, gap_col1, held_bad, stall_left;
  int cen_cnt  [MX];
  int cset_cnt [MX];
  int cset_cyc [MX];
  bit chain [MX][$];
  logic [MX-1:0] last_shift;
  logic [WW-1:0] load_words [NW];
  logic [WW-1:0] host_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs_a();
    return 64'({cen_a, cset_a, shift_in_a, busy_a, in_ready_a, done_a});
  endfunction

  function automatic logic [63:0] outs_b();
    return 64'({cen_b, cset_b, shift_in_b, busy_b, in_ready_b, done_b});
  endfunction

  // Column c is the first CB bits of its WPC words, each word LSB first.
  function automatic logic [63:0] exp_col(input int c);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < CB; i++) v[i] = load_words[c*WPC + i/WW][i%WW];
    return v;
  endfunction

  function automatic logic [63:0] got_col(input int c);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < chain[c].size() && i < 64; i++) v[i] = chain[c][i];
    return v;
  endfunction

  task automatic reset_obs();
    cyc = 0; first_cen = -1; done_cnt = 0; done_cyc = 0; hs_cnt = 0; viol = 0;
    gap_cnt = 0; gap_col1 = 0; held_bad = 0; stall_left = 0; last_shift = '0;
    for (int c = 0; c < MX; c++) begin
      cen_cnt[c] = 0; cset_cnt[c] = 0; cset_cyc[c] = 0;
      chain[c].delete();
    end
    host_q.delete();
  endtask

  // One cycle: observe outputs at the falling edge, then drive inputs for the next rising edge.
  task automatic tick_a(input bit do_start);
    @(negedge clk);
    cyc++;
    if ($countones(cen_a) > 1 || $countones(cset_a) > 1 || ((|cen_a) && (|cset_a))) viol++;
    if ((|cen_a) && ((shift_in_a & ~cen_a) != '0)) viol++;
    if (|cen_a) begin
      last_shift = shift_in_a;
    end else if (first_cen >= 0 && done_cnt == 0 && busy_a && !done_a && cset_a == '0) begin
      gap_cnt++;
      if (cset_cnt[0] == 1 && cset_cnt[1] == 0) gap_col1++;
      if (shift_in_a !== last_shift) held_bad++;
    end
    for (int c = 0; c < MX; c++) begin
      if (cen_a[c]) begin
        chain[c].push_back(shift_in_a[c]);
        cen_cnt[c]++;
        if (first_cen < 0) first_cen = cyc;
      end
      if (cset_a[c]) begin
        cset_cnt[c]++;
        cset_cyc[c] = cyc;
      end
    end
    if (done_a) begin
      done_cnt++;
      done_cyc = cyc;
    end

    start_a = do_start;
    // Withholding applies to the second word of column 1 (word index 3).
    if (stall_left > 0 && hs_cnt == 3 && in_ready_a) begin
      in_valid_a = 1'b0;
      stall_left--;
    end else begin
      in_valid_a = (host_q.size() > 0);
    end
    if (in_valid_a) in_data_a = host_q[0];
    else            in_data_a = '0;
    if (in_valid_a && in_ready_a) begin
      void'(host_q.pop_front());
      hs_cnt++;
    end
  endtask

  task automatic run_load(input string name, input int stall, input int exp_gap);
    int n;
    reset_obs();
    stall_left = stall;
    for (int i = 0; i < NW; i++) host_q.push_back(load_words[i]);
    tick_a(1'b1);
    n = 0;
    while (done_cnt == 0 && n < 800) begin
      tick_a(1'b0);
      n++;
    end
    repeat (4) tick_a(1'b0);

    for (int c = 0; c < MX; c++) begin
      check($sformatf("%s col%0d bits", name, c), got_col(c), exp_col(c));
      check($sformatf("%s col%0d cen cycles", name, c), cen_cnt[c], CB);
      check($sformatf("%s col%0d cset pulses", name, c), cset_cnt[c], 1);
    end
    check({name, " cset0 after 40 cen"}, cset_cyc[0] - first_cen, CB);
    check({name, " done pulses"}, done_cnt, 1);
    check({name, " done latency"}, done_cyc - first_cen, MX * (CB + 1) + exp_gap);
    check({name, " handshakes"}, hs_cnt, NW);
    check({name, " onehot violations"}, viol, 0);
    check({name, " stall gaps"}, gap_cnt, exp_gap);
    check({name, " stall gaps in col1"}, gap_col1, exp_gap);
    check({name, " shift_in held"}, held_bad, 0);
    check({name, " busy low after"}, busy_a, 1'b0);
  endtask

  initial begin
    int n;
    logic [31:0] bw, gotb;
    int bcen, bcset, bdone, bhs, bfirst, bdonecyc;
    bit bsent;

    reset_obs();

    // Reset and idle.
    repeat (3) @(negedge clk);
    check("in reset outputs A", outs_a(), 64'd0);
    check("in reset outputs B", outs_b(), 64'd0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle outputs A", outs_a(), 64'd0);
      check("idle outputs B", outs_b(), 64'd0);
    end

    // Directed pattern: A5A5A5A5 then 000000F0 per column.
    for (int c = 0; c < MX; c++) begin
      load_words[c*WPC]     = 32'hA5A5_A5A5;
      load_words[c*WPC + 1] = 32'h0000_00F0;
    end
    run_load("pattern", 0, 0);

    // Upper 24 bits of each column's second word must be discarded.
    for (int c = 0; c < MX; c++) begin
      load_words[c*WPC]     = $urandom();
      load_words[c*WPC + 1] = 32'hFFFF_FF00;
    end
    run_load("discard", 0, 0);

    // Backpressure: five withheld cycles; one still consumes the last buffered bit,
    // so the fabric sees four cycles without cen.
    for (int i = 0; i < NW; i++) load_words[i] = $urandom();
    run_load("stall", 5, 4);

    // Reset mid-load at the 20th bit of column 2.
    for (int i = 0; i < NW; i++) load_words[i] = $urandom();
    reset_obs();
    for (int i = 0; i < NW; i++) host_q.push_back(load_words[i]);
    tick_a(1'b1);
    n = 0;
    while (chain[2].size() < 20 && n < 800) begin
      tick_a(1'b0);
      n++;
    end
    check("abort trigger reached", chain[2].size(), 20);
    rst        = 1'b0;
    in_valid_a = 1'b0;
    #1;
    check("abort async outputs", outs_a(), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort hold outputs", outs_a(), 64'd0);
    end
    rst = 1'b1;
    host_q.delete();
    repeat (6) tick_a(1'b0);
    check("abort no cset2", cset_cnt[2], 0);
    check("abort no done", done_cnt, 0);
    check("abort col2 stopped", chain[2].size(), 20);
    check("abort busy low", busy_a, 1'b0);

    for (int i = 0; i < NW; i++) load_words[i] = $urandom();
    run_load("reload", 0, 0);

    // Corner: one column of one word, start re-pulsed while busy.
    bw = $urandom(); gotb = '0;
    bcen = 0; bcset = 0; bdone = 0; bhs = 0; bfirst = -1; bdonecyc = 0; bsent = 1'b0;
    @(negedge clk);
    start_b = 1'b1;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      if (cen_b[0]) begin
        if (bcen < 32) gotb[bcen] = shift_in_b[0];
        if (bfirst < 0) bfirst = k;
        bcen++;
      end
      if (cset_b[0]) bcset++;
      if (done_b) begin
        bdone++;
        bdonecyc = k;
      end
      start_b    = busy_b && (k % 7 == 0);
      in_valid_b = !bsent;
      in_data_b  = bw;
      if (in_valid_b && in_ready_b) begin
        bsent = 1'b1;
        bhs++;
      end
    end
    start_b    = 1'b0;
    in_valid_b = 1'b0;
    check("corner bits", gotb, bw);
    check("corner cen cycles", bcen, BCB);
    check("corner cset pulses", bcset, 1);
    check("corner done pulses", bdone, 1);
    check("corner done latency", bdonecyc - bfirst, BCB + 1);
    check("corner handshakes", bhs, 1);
    check("corner busy low", busy_b, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
